// File: rtl/aes_pkg.sv
// Shared AES round types, the GF(2^8) reduction polynomial and xtime.
package aes_pkg;
   typedef logic [127:0] state_t;
   typedef logic [7:0]   byte_t;
   typedef logic [3:0]   round_t;

   typedef struct packed {
      state_t data;
      round_t round;
      logic   last;
   } beat_t;

   localparam byte_t AES_POLY = 8'h1b;

   function automatic byte_t xtime(input byte_t b);
      return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
   endfunction
endpackage

// File: rtl/shift_mix_ark_mix_column.sv
// Combinational MixColumns of one 32-bit column; byte 0 (row 0) sits in the MSBs.
module mix_column
   import aes_pkg::*;
(
   input  logic [31:0] col_i,
   output logic [31:0] col_o
);
   byte_t a0, a1, a2, a3;
   byte_t x0, x1, x2, x3;

   assign a0 = col_i[31:24];
   assign a1 = col_i[23:16];
   assign a2 = col_i[15:8];
   assign a3 = col_i[7:0];
   assign x0 = xtime(a0);
   assign x1 = xtime(a1);
   assign x2 = xtime(a2);
   assign x3 = xtime(a3);

   // 3*a is written as xtime(a) ^ a.
   assign col_o[31:24] = x0 ^ (x1 ^ a1) ^ a2 ^ a3;
   assign col_o[23:16] = a0 ^ x1 ^ (x2 ^ a2) ^ a3;
   assign col_o[15:8]  = a0 ^ a1 ^ x2 ^ (x3 ^ a3);
   assign col_o[7:0]   = (x0 ^ a0) ^ a1 ^ a2 ^ x3;
endmodule

// File: rtl/shift_mix_ark.sv
// AES ShiftRows -> MixColumns (skipped on last round) -> AddRoundKey, one registered stage.
// Define AES_SKID_EN to add a 2-entry skid buffer so in_ready is a flop with no path from out_ready.
module shift_mix_ark
   import aes_pkg::*;
(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_data,
   input  logic [127:0] in_key,
   input  logic [3:0]   in_round,
   input  logic         in_last,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_data,
   output logic [3:0]   out_round,
   output logic         out_last
);
   state_t sr_s;
   state_t mc_s;
   beat_t  in_beat_s;
   beat_t  out_q, out_d;
   logic   valid_q, valid_d;

   // Row r of the column-major state rotates left by r columns.
   always_comb begin
      sr_s = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            sr_s[127-8*(r+4*c) -: 8] = in_data[127-8*(r+4*((c+r)%4)) -: 8];
         end
      end
   end

   for (genvar c = 0; c < 4; c++) begin : g_mix
      mix_column u_mix_column (
         .col_i (sr_s[127-32*c -: 32]),
         .col_o (mc_s[127-32*c -: 32])
      );
   end

   always_comb begin
      in_beat_s.data  = (in_last ? sr_s : mc_s) ^ in_key;
      in_beat_s.round = in_round;
      in_beat_s.last  = in_last;
   end

`ifdef AES_SKID_EN
   beat_t      skid0_q, skid0_d;
   beat_t      skid1_q, skid1_d;
   logic [1:0] cnt_q, cnt_d;
   logic       rdy_q, rdy_d;
   logic       acc_s;

   assign in_ready = rdy_q;
   assign acc_s    = in_valid && rdy_q;

   // Output register refills from the oldest skid entry first so order is preserved.
   always_comb begin
      out_d   = out_q;
      valid_d = valid_q;
      skid0_d = skid0_q;
      skid1_d = skid1_q;
      cnt_d   = cnt_q;
      if (!valid_q || out_ready) begin
         case (cnt_q)
            2'd0: begin
               if (acc_s) begin
                  out_d   = in_beat_s;
                  valid_d = 1'b1;
               end else begin
                  valid_d = 1'b0;
               end
            end
            2'd1: begin
               out_d   = skid0_q;
               valid_d = 1'b1;
               if (acc_s) begin
                  skid0_d = in_beat_s;
               end else begin
                  cnt_d = 2'd0;
               end
            end
            2'd2: begin
               out_d   = skid0_q;
               valid_d = 1'b1;
               skid0_d = skid1_q;
               if (acc_s) begin
                  skid1_d = in_beat_s;
               end else begin
                  cnt_d = 2'd1;
               end
            end
            default: begin
               cnt_d = 2'd0;
            end
         endcase
      end else if (acc_s) begin
         case (cnt_q)
            2'd0: begin
               skid0_d = in_beat_s;
               cnt_d   = 2'd1;
            end
            2'd1: begin
               skid1_d = in_beat_s;
               cnt_d   = 2'd2;
            end
            default: begin
               cnt_d = cnt_q;
            end
         endcase
      end else begin
         cnt_d = cnt_q;
      end
      rdy_d = (cnt_d != 2'd2);
   end

   // Skid storage and the registered ready flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         skid0_q <= '0;
         skid1_q <= '0;
         cnt_q   <= 2'd0;
         rdy_q   <= 1'b1;
      end else begin
         skid0_q <= skid0_d;
         skid1_q <= skid1_d;
         cnt_q   <= cnt_d;
         rdy_q   <= rdy_d;
      end
   end
`else
   assign in_ready = !valid_q || out_ready;

   // Load on accept (also covers accept-while-draining); otherwise clear valid once drained.
   always_comb begin
      out_d   = out_q;
      valid_d = valid_q;
      if (in_valid && in_ready) begin
         out_d   = in_beat_s;
         valid_d = 1'b1;
      end else if (out_ready) begin
         valid_d = 1'b0;
      end else begin
         valid_d = valid_q;
      end
   end
`endif

   // Output stage register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         out_q   <= out_d;
         valid_q <= valid_d;
      end
   end

   assign out_valid = valid_q;
   assign out_data  = out_q.data;
   assign out_round = out_q.round;
   assign out_last  = out_q.last;
endmodule

// File: tb/tb_shift_mix_ark.sv
// Self-checking bench for shift_mix_ark: byte-level AES round model, randomized traffic and stalls.
module tb_shift_mix_ark;
   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [127:0] in_data = '0;
   logic [127:0] in_key = '0;
   logic [3:0]   in_round = '0;
   logic         in_last = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [127:0] out_data;
   logic [3:0]   out_round;
   logic         out_last;

   shift_mix_ark dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_key    (in_key),
      .in_round  (in_round),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_round (out_round),
      .out_last  (out_last)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [127:0] d;
      logic [3:0]   r;
      logic         l;
      logic         has_lit;
      logic [127:0] lit;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;

   logic         drv_lit_en = 1'b0;
   logic [127:0] drv_lit = '0;
   logic         drv_timeout = 1'b0;
   logic         rand_ready = 1'b0;
   int           phase = 0;
   int           tp_drains = 0;
   logic         tp_done = 1'b0;
   logic         prev_stall = 1'b0;
   logic [127:0] prev_data;
   logic [3:0]   prev_round;
   logic         prev_last;

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      end
      return p;
   endfunction

   function automatic logic [127:0] model(input logic [127:0] d, input logic [127:0] k, input logic l);
      logic [7:0]   b[16];
      logic [7:0]   s[16];
      logic [7:0]   m[16];
      logic [7:0]   base[4];
      logic [127:0] o;
      base = '{8'h02, 8'h03, 8'h01, 8'h01};
      for (int i = 0; i < 16; i++) b[i] = d[127-8*i -: 8];
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            s[r+4*c] = b[r+4*((c+r)%4)];
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++) begin
            m[r+4*c] = 8'h00;
            for (int j = 0; j < 4; j++)
               m[r+4*c] = m[r+4*c] ^ gmul(base[(j-r+4)%4], s[j+4*c]);
         end
      o = '0;
      for (int i = 0; i < 16; i++) o[127-8*i -: 8] = (l ? s[i] : m[i]) ^ k[127-8*i -: 8];
      return o;
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Single compare process: outputs vs. the queue of beats that must be in flight.
   always @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q.delete();
         prev_stall = 1'b0;
         #1;
         chk("reset_out_valid", {127'd0, out_valid}, 128'd0);
         chk("reset_out_data", out_data, 128'd0);
         chk("reset_out_round", {124'd0, out_round}, 128'd0);
         chk("reset_out_last", {127'd0, out_last}, 128'd0);
      end else begin
         exp_t e;
         logic acc, drn;
         chk("handshake_timeout", {127'd0, drv_timeout}, 128'd0);
         chk("out_valid", {127'd0, out_valid}, {127'd0, q.size() != 0});
         if (out_valid && q.size() != 0) begin
            chk("out_data", out_data, q[0].d);
            chk("out_round", {124'd0, out_round}, {124'd0, q[0].r});
            chk("out_last", {127'd0, out_last}, {127'd0, q[0].l});
            if (q[0].has_lit) chk("literal_out_data", out_data, q[0].lit);
         end
         if (prev_stall) begin
            chk("stall_valid", {127'd0, out_valid}, 128'd1);
            chk("stall_data", out_data, prev_data);
            chk("stall_round", {124'd0, out_round}, {124'd0, prev_round});
            chk("stall_last", {127'd0, out_last}, {127'd0, prev_last});
         end
`ifdef AES_SKID_EN
         chk("in_ready", {127'd0, in_ready}, {127'd0, q.size() <= 2});
`else
         chk("in_ready", {127'd0, in_ready}, {127'd0, !out_valid || out_ready});
`endif
         if (phase == 2 && out_valid && out_ready) tp_drains++;
         if (phase == 3 && !tp_done) begin
            chk("throughput", tp_drains, 128'd16);
            tp_done = 1'b1;
         end
         acc = in_valid && in_ready;
         drn = out_valid && out_ready;
         prev_stall = out_valid && !out_ready;
         prev_data  = out_data;
         prev_round = out_round;
         prev_last  = out_last;
         if (drn && q.size() != 0) void'(q.pop_front());
         if (acc) begin
            e.d = model(in_data, in_key, in_last);
            e.r = in_round;
            e.l = in_last;
            e.has_lit = drv_lit_en;
            e.lit = drv_lit;
            if (drv_lit_en) chk("model_pin", e.d, drv_lit);
            q.push_back(e);
         end
      end
   end

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
   endtask

   task automatic send(input logic [127:0] d, input logic [127:0] k, input logic [3:0] r,
                       input logic l, input logic le, input logic [127:0] lit);
      int   n = 0;
      logic got = 1'b0;
      in_valid = 1'b1;
      in_data = d;
      in_key = k;
      in_round = r;
      in_last = l;
      drv_lit_en = le;
      drv_lit = lit;
      while (!got && n < 100) begin
         @(negedge clk);
         got = in_ready;
         tick();
         n++;
      end
      if (!got) drv_timeout = 1'b1;
      in_valid = 1'b0;
      drv_lit_en = 1'b0;
      in_data = rnd128();
      in_key = rnd128();
      in_round = 4'($urandom);
      in_last = 1'($urandom);
   endtask

   task automatic drain();
      int n = 0;
      rand_ready = 1'b0;
      out_ready = 1'b1;
      while (out_valid && n < 50) begin
         tick();
         n++;
      end
      if (out_valid) drv_timeout = 1'b1;
   endtask

   initial begin
      repeat (3) @(negedge clk);
      @(posedge clk);
      #2 rst_n = 1'b1;
      tick();

      out_ready = 1'b1;
      send(128'hd42711aee0bf98f1b8b45de51e415230, 128'ha0fafe1788542cb123a339392a6c7605,
           4'h1, 1'b0, 1'b1, 128'ha49c7ff2689f352b6b5bea43026a5049);
      send(128'h000102030405060708090a0b0c0d0e0f, 128'd0,
           4'ha, 1'b1, 1'b1, 128'h00050a0f04090e03080d02070c01060b);
      send(128'hdb135345db135345db135345db135345, 128'd0,
           4'h7, 1'b0, 1'b1, 128'h8e4da1bc8e4da1bc8e4da1bc8e4da1bc);
      drain();

      for (int rep = 0; rep < 4; rep++) begin
         rand_ready = 1'b1;
         for (int b = 0; b < 8; b++) begin
            repeat ($urandom_range(0, 2)) tick();
            send(rnd128(), rnd128(), 4'($urandom), 1'($urandom), 1'b0, 128'd0);
         end
         drain();
      end

      rand_ready = 1'b0;
      out_ready = 1'b1;
      phase = 2;
      in_valid = 1'b1;
      for (int i = 0; i < 16; i++) begin
         in_data = rnd128();
         in_key = rnd128();
         in_round = 4'(i);
         in_last = 1'($urandom);
         @(negedge clk);
         tick();
      end
      in_valid = 1'b0;
      @(negedge clk);
      tick();
      phase = 3;
      tick();

      out_ready = 1'b0;
      send(rnd128(), rnd128(), 4'h5, 1'b0, 1'b0, 128'd0);
      #2 rst_n = 1'b0;
      #6 rst_n = 1'b1;
      tick();
      out_ready = 1'b1;
      send(128'hd42711aee0bf98f1b8b45de51e415230, 128'ha0fafe1788542cb123a339392a6c7605,
           4'h2, 1'b0, 1'b1, 128'ha49c7ff2689f352b6b5bea43026a5049);
      drain();
      tick();
      tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
